// File: rtl/alu_up_regs_if.sv
// Host-side 8-bit pi_* register bus plus the completion interrupt handshake.
interface alu_up_regs_if;
   logic       pi_blk_sel;
   logic       pi_wr_en;
   logic       pi_rd_en;
   logic [3:0] pi_addr;
   logic [7:0] pi_wr_data;
   logic [7:0] pi_rd_data;
   logic       interrupt;
   logic       interrupt_ack;

   modport master (
      output pi_blk_sel, pi_wr_en, pi_rd_en, pi_addr, pi_wr_data, interrupt_ack,
      input  pi_rd_data, interrupt
   );

   modport slave (
      input  pi_blk_sel, pi_wr_en, pi_rd_en, pi_addr, pi_wr_data, interrupt_ack,
      output pi_rd_data, interrupt
   );
endinterface

// File: rtl/alu_up_regs.sv
// Register front-end for the fixed-point ALU: operand/opcode registers,
// launch/complete FSM with watchdog, W1C status and a level interrupt.
module alu_up_regs #(
   parameter int         DW       = 32,
   parameter int         TIMEOUT  = 1024,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic          clk,
   input  logic          rst,
   alu_up_regs_if.slave  bus,
   output logic          alu_start,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic          alu_done,
   input  logic [DW-1:0] alu_result
);
   localparam int          CW = $clog2(TIMEOUT);
   localparam int unsigned NB = DW / 8;

   typedef enum logic {S_IDLE, S_BUSY} state_t;
   state_t state, state_nx;

   logic          wr, rd, start_wr;
   logic          busy, launch, tmo_hit, done_set, tmo_set, ovr_set, irq_set;
   logic [CW-1:0] cnt;
   logic [31:0]   a_q, b_q, res_q;
   logic [3:0]    op_q;
   logic          irq_en, done_q, ovr_q, tmo_q, int_q;
   logic [7:0]    rd_q, rd_mux;

   // Qualified bus strobes; a write shadows a simultaneous read.
   assign wr       = bus.pi_blk_sel & bus.pi_wr_en;
   assign rd       = bus.pi_blk_sel & bus.pi_rd_en & ~bus.pi_wr_en;
   assign start_wr = wr & (bus.pi_addr == 4'h0) & bus.pi_wr_data[0];

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state: launch on START in IDLE; leave BUSY on done or watchdog.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start_wr) state_nx = S_BUSY;
         S_BUSY: if (alu_done || tmo_hit) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM-derived events; alu_done takes priority over the watchdog.
   always_comb begin
      busy     = (state == S_BUSY);
      launch   = ~busy & start_wr;
      tmo_hit  = busy & (cnt == CW'(TIMEOUT - 1));
      done_set = busy & alu_done;
      tmo_set  = tmo_hit & ~alu_done;
      ovr_set  = busy & start_wr;
      irq_set  = irq_en & (done_set | tmo_set);
   end

   // Launch pulse and watchdog counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_start <= 1'b0;
         cnt       <= '0;
      end else begin
         alu_start <= launch;
         if (launch)    cnt <= '0;
         else if (busy) cnt <= cnt + 1'b1;
      end
   end

   // Operand/opcode/control registers; operands frozen while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         irq_en <= 1'b0;
      end else if (wr) begin
         if (bus.pi_addr == 4'h0) irq_en <= bus.pi_wr_data[1];
         if (!busy) begin
            if (bus.pi_addr == 4'hA) op_q <= bus.pi_wr_data[3:0];
            for (int unsigned k = 0; k < 4; k++) begin
               if (k < NB && bus.pi_addr == 4'(k + 2)) a_q[8*k +: 8] <= bus.pi_wr_data;
               if (k < NB && bus.pi_addr == 4'(k + 6)) b_q[8*k +: 8] <= bus.pi_wr_data;
            end
         end
      end
   end

   // Status flags and result capture; hardware sets beat W1C clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         tmo_q  <= 1'b0;
         res_q  <= '0;
      end else begin
         if (done_set) res_q <= 32'(alu_result);
         if (done_set)
            done_q <= 1'b1;
         else if (launch || (wr && bus.pi_addr == 4'h1 && bus.pi_wr_data[1]))
            done_q <= 1'b0;
         if (tmo_set)
            tmo_q <= 1'b1;
         else if (launch || (wr && bus.pi_addr == 4'h1 && bus.pi_wr_data[3]))
            tmo_q <= 1'b0;
         if (ovr_set)
            ovr_q <= 1'b1;
         else if (wr && bus.pi_addr == 4'h1 && bus.pi_wr_data[2])
            ovr_q <= 1'b0;
      end
   end

   // Level interrupt: set wins over acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   int_q <= 1'b0;
      else if (irq_set)           int_q <= 1'b1;
      else if (bus.interrupt_ack) int_q <= 1'b0;
   end

   // Read mux; upper operand/result bytes stay zero when DW < 32.
   always_comb begin
      rd_mux = '0;
      case (bus.pi_addr)
         4'h0: rd_mux = {6'b0, irq_en, 1'b0};
         4'h1: rd_mux = {4'b0, tmo_q, ovr_q, done_q, busy};
         4'h2: rd_mux = a_q[7:0];
         4'h3: rd_mux = a_q[15:8];
         4'h4: rd_mux = a_q[23:16];
         4'h5: rd_mux = a_q[31:24];
         4'h6: rd_mux = b_q[7:0];
         4'h7: rd_mux = b_q[15:8];
         4'h8: rd_mux = b_q[23:16];
         4'h9: rd_mux = b_q[31:24];
         4'hA: rd_mux = {4'b0, op_q};
         4'hB: rd_mux = res_q[7:0];
         4'hC: rd_mux = res_q[15:8];
         4'hD: rd_mux = res_q[23:16];
         4'hE: rd_mux = res_q[31:24];
         4'hF: rd_mux = ID_VALUE;
         default: rd_mux = '0;
      endcase
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rd_q <= '0;
      else if (rd) rd_q <= rd_mux;
   end

   assign bus.pi_rd_data = rd_q;
   assign bus.interrupt  = int_q;
   assign alu_op         = op_q;
   assign alu_a          = a_q[DW-1:0];
   assign alu_b          = b_q[DW-1:0];
endmodule

// File: tb/tb_alu_up_regs.sv
// Directed bench for alu_up_regs: register map, launch/complete,
// overrun, watchdog, set-vs-clear priorities and mid-operation reset.
module tb_alu_up_regs;
   logic        clk;
   logic        rst;
   logic        alu_start;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_done;
   int          checks, errors;
   logic [7:0]  d;

   alu_up_regs_if bus ();

   alu_up_regs #(.DW(32), .TIMEOUT(16), .ID_VALUE(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus.pi_blk_sel = 1'b1; bus.pi_wr_en = 1'b1;
      bus.pi_addr = addr;    bus.pi_wr_data = data;
      @(negedge clk);
      bus.pi_blk_sel = 1'b0; bus.pi_wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus.pi_blk_sel = 1'b1; bus.pi_rd_en = 1'b1; bus.pi_addr = addr;
      @(negedge clk);
      bus.pi_blk_sel = 1'b0; bus.pi_rd_en = 1'b0;
      data = bus.pi_rd_data;
   endtask

   task automatic alu_respond(input logic [31:0] r);
      @(negedge clk);
      alu_done = 1'b1; alu_result = r;
      @(negedge clk);
      alu_done = 1'b0;
   endtask

   task automatic ack_irq();
      @(negedge clk);
      bus.interrupt_ack = 1'b1;
      @(negedge clk);
      bus.interrupt_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", alu_start); end
      checks++; if (bus.pi_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", bus.pi_rd_data); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus_read(4'hF, d);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL id_read got %h exp a5", d); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", d); end
      checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.interrupt); end
   endtask

   task automatic test_operation();
      bus_write(4'h2, 8'h00); bus_write(4'h3, 8'h00); bus_write(4'h4, 8'h01); bus_write(4'h5, 8'h00);
      bus_write(4'h6, 8'h00); bus_write(4'h7, 8'h00); bus_write(4'h8, 8'h02); bus_write(4'h9, 8'h00);
      bus_write(4'hA, 8'h02);
      bus_write(4'h0, 8'h03);
      checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b exp 1", alu_start); end
      checks++; if (alu_a !== 32'h00010000) begin errors++; $display("FAIL op_a got %h exp 00010000", alu_a); end
      checks++; if (alu_b !== 32'h00020000) begin errors++; $display("FAIL op_b got %h exp 00020000", alu_b); end
      checks++; if (alu_op !== 4'h2) begin errors++; $display("FAIL op_code got %h exp 2", alu_op); end
      @(negedge clk);
      checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL start_width got %b exp 0", alu_start); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL busy_status got %h exp 01", d); end
      alu_respond(32'h00020000);
      checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL done_irq got %b exp 1", bus.interrupt); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL done_status got %h exp 02", d); end
      bus_read(4'hB, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL res_b0 got %h exp 00", d); end
      bus_read(4'hC, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL res_b1 got %h exp 00", d); end
      bus_read(4'hD, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL res_b2 got %h exp 02", d); end
      bus_read(4'hE, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL res_b3 got %h exp 00", d); end
      ack_irq();
      checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", bus.interrupt); end
   endtask

   task automatic test_overrun();
      bus_write(4'h0, 8'h01);
      bus_write(4'h2, 8'hFF);
      checks++; if (alu_a !== 32'h00010000) begin errors++; $display("FAIL busy_a_write got %h exp 00010000", alu_a); end
      bus_write(4'h0, 8'h01);
      bus_read(4'h1, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL ovr_status got %h exp 05", d); end
      bus_write(4'h1, 8'h04);
      bus_read(4'h1, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovr_w1c got %h exp 01", d); end
      alu_respond(32'h12345678);
      checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL noirq_done got %b exp 0", bus.interrupt); end
      bus_read(4'hE, d);
      checks++; if (d !== 8'h12) begin errors++; $display("FAIL ovr_res_b3 got %h exp 12", d); end
   endtask

   task automatic test_timeout();
      bus_write(4'h0, 8'h03);
      repeat (15) @(negedge clk);
      checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", bus.interrupt); end
      @(negedge clk);
      checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL tmo_irq got %b exp 1", bus.interrupt); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL tmo_status got %h exp 08", d); end
      ack_irq();
      alu_respond(32'hDEADBEEF);
      bus_read(4'hB, d);
      checks++; if (d !== 8'h78) begin errors++; $display("FAIL late_done_res got %h exp 78", d); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL late_done_status got %h exp 08", d); end
      checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL late_done_irq got %b exp 0", bus.interrupt); end
   endtask

   task automatic test_set_priority();
      bus_write(4'h0, 8'h03);
      alu_respond(32'h00000011);
      bus_write(4'h0, 8'h03);
      @(negedge clk);
      alu_done = 1'b1; alu_result = 32'h00000022;
      bus.interrupt_ack = 1'b1;
      bus.pi_blk_sel = 1'b1; bus.pi_wr_en = 1'b1; bus.pi_addr = 4'h1; bus.pi_wr_data = 8'h02;
      @(negedge clk);
      alu_done = 1'b0; bus.interrupt_ack = 1'b0;
      bus.pi_blk_sel = 1'b0; bus.pi_wr_en = 1'b0;
      checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL set_vs_ack got %b exp 1", bus.interrupt); end
      bus_read(4'h1, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL set_vs_w1c got %h exp 02", d); end
      bus_read(4'hB, d);
      checks++; if (d !== 8'h22) begin errors++; $display("FAIL prio_res got %h exp 22", d); end
      ack_irq();
   endtask

   task automatic test_reset_busy();
      bus_write(4'h0, 8'h03);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if ({alu_start, bus.interrupt, bus.pi_rd_data, alu_op} !== 14'h0) begin errors++; $display("FAIL mid_rst_outs got %h exp 0", {alu_start, bus.interrupt, bus.pi_rd_data, alu_op}); end
      checks++; if ({alu_a, alu_b} !== 64'h0) begin errors++; $display("FAIL mid_rst_ops got %h exp 0", {alu_a, alu_b}); end
      @(negedge clk);
      rst = 1'b1;
      alu_respond(32'h00000099);
      bus_read(4'h1, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_rst_status got %h exp 00", d); end
      bus_read(4'hB, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_rst_res got %h exp 00", d); end
      bus_write(4'h0, 8'h01);
      checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL relaunch_start got %b exp 1", alu_start); end
      alu_respond(32'h000000AB);
      bus_read(4'hB, d);
      checks++; if (d !== 8'hAB) begin errors++; $display("FAIL relaunch_res got %h exp ab", d); end
   endtask

   task automatic test_bus_rules();
      bus_read(4'hF, d);
      @(negedge clk);
      bus.pi_blk_sel = 1'b1; bus.pi_wr_en = 1'b1; bus.pi_rd_en = 1'b1;
      bus.pi_addr = 4'hA; bus.pi_wr_data = 8'h07;
      @(negedge clk);
      bus.pi_blk_sel = 1'b0; bus.pi_wr_en = 1'b0; bus.pi_rd_en = 1'b0;
      checks++; if (bus.pi_rd_data !== 8'hA5) begin errors++; $display("FAIL wr_rd_hold got %h exp a5", bus.pi_rd_data); end
      checks++; if (alu_op !== 4'h7) begin errors++; $display("FAIL wr_rd_write got %h exp 7", alu_op); end
      @(negedge clk);
      bus.pi_wr_en = 1'b1; bus.pi_addr = 4'hA; bus.pi_wr_data = 8'h03;
      @(negedge clk);
      bus.pi_wr_en = 1'b0;
      checks++; if (alu_op !== 4'h7) begin errors++; $display("FAIL blk_sel_gate got %h exp 7", alu_op); end
      bus_write(4'hF, 8'h00);
      bus_read(4'hF, d);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ro_write got %h exp a5", d); end
      bus_read(4'h0, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL ctrl_read got %h exp 00", d); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0;
      alu_done = 1'b0; alu_result = '0;
      bus.pi_blk_sel = 1'b0; bus.pi_wr_en = 1'b0; bus.pi_rd_en = 1'b0;
      bus.pi_addr = '0; bus.pi_wr_data = '0; bus.interrupt_ack = 1'b0;
      test_reset();
      test_operation();
      test_overrun();
      test_timeout();
      test_set_priority();
      test_reset_busy();
      test_bus_rules();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
